// File: rtl/vjtag_dsa_ctrl.sv
// Virtual-JTAG command controller: IR decode, LSB-first DR shifting, auto-incrementing memory port.
// Writes reach memory 1 tck after Update-DR, read data lands in rbuf 2 tck after a read strobe; no backpressure.
module vjtag_dsa_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
) (
  input  logic              tck,
  input  logic              rst_n,
  input  logic              tdi,
  output logic              tdo,
  input  logic [1:0]        ir_in,
  output logic [1:0]        ir_out,
  input  logic              virtual_state_cdr,
  input  logic              virtual_state_sdr,
  input  logic              virtual_state_udr,
  input  logic              virtual_state_uir,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IR_BYPASS = 2'b00,
    IR_WADDR  = 2'b01,
    IR_WDATA  = 2'b10,
    IR_RDATA  = 2'b11
  } ir_e;

  ir_e ir;
  assign ir = ir_e'(ir_in);

  logic              byp_q, byp_d;
  logic [ADDR_W-1:0] addr_sr_q, addr_sr_d;
  logic [DATA_W-1:0] data_sr_q, data_sr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_re_q, mem_re_d;
  logic              re_dly_q, re_dly_d;
  logic [DATA_W-1:0] rbuf_q, rbuf_d;
  logic              rbuf_valid_q, rbuf_valid_d;
  logic              wrap_q, wrap_d;
  logic [ADDR_W:0]   addr_inc;

  // Extra MSB is the carry out of 0xFF..F, which raises the sticky wrap flag.
  assign addr_inc = {1'b0, addr_q} + {{ADDR_W{1'b0}}, 1'b1};

  always_comb begin
    byp_d        = byp_q;
    addr_sr_d    = addr_sr_q;
    data_sr_d    = data_sr_q;
    addr_d       = addr_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = 1'b0;
    mem_re_d     = 1'b0;
    re_dly_d     = mem_re_q;
    rbuf_d       = rbuf_q;
    rbuf_valid_d = rbuf_valid_q;
    wrap_d       = wrap_q;

    // Memory returns data the cycle after the strobe; capture it one edge later.
    if (re_dly_q) begin
      rbuf_d       = mem_rdata;
      rbuf_valid_d = 1'b1;
    end

    if (virtual_state_sdr) begin
      case (ir)
        IR_BYPASS: byp_d     = tdi;
        IR_WADDR:  addr_sr_d = {tdi, addr_sr_q[ADDR_W-1:1]};
        default:   data_sr_d = {tdi, data_sr_q[DATA_W-1:1]};
      endcase
    end

    if (virtual_state_cdr && ir == IR_RDATA) data_sr_d = rbuf_q;

    if (virtual_state_udr) begin
      case (ir)
        IR_WADDR: begin
          addr_d = addr_sr_q;
          wrap_d = 1'b0;
        end
        IR_WDATA: begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = data_sr_q;
          addr_d      = addr_inc[ADDR_W-1:0];
          if (addr_inc[ADDR_W]) wrap_d = 1'b1;
        end
        IR_RDATA: begin
          mem_re_d   = 1'b1;
          mem_addr_d = addr_inc[ADDR_W-1:0];
          addr_d     = addr_inc[ADDR_W-1:0];
          if (addr_inc[ADDR_W]) wrap_d = 1'b1;
        end
        default: ;
      endcase
    end

    // Prefetch so the first Capture-DR after selecting READ_DATA has data ready.
    if (virtual_state_uir && ir == IR_RDATA) begin
      mem_re_d   = 1'b1;
      mem_addr_d = addr_q;
    end

    if (mem_re_d) rbuf_valid_d = 1'b0;
  end

  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      byp_q        <= 1'b0;
      addr_sr_q    <= '0;
      data_sr_q    <= '0;
      addr_q       <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      re_dly_q     <= 1'b0;
      rbuf_q       <= '0;
      rbuf_valid_q <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      byp_q        <= byp_d;
      addr_sr_q    <= addr_sr_d;
      data_sr_q    <= data_sr_d;
      addr_q       <= addr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      mem_re_q     <= mem_re_d;
      re_dly_q     <= re_dly_d;
      rbuf_q       <= rbuf_d;
      rbuf_valid_q <= rbuf_valid_d;
      wrap_q       <= wrap_d;
    end
  end

  always_comb begin
    case (ir)
      IR_BYPASS: tdo = byp_q;
      IR_WADDR:  tdo = addr_sr_q[0];
      default:   tdo = data_sr_q[0];
    endcase
  end

  assign ir_out    = {wrap_q, rbuf_valid_q};
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;

endmodule

// File: tb/tb_vjtag_dsa_ctrl.sv
// Directed bench for vjtag_dsa_ctrl with a synchronous memory model and write/read strobe monitor.
module tb_vjtag_dsa_ctrl;

  logic        tck = 1'b0;
  logic        rst_n;
  logic        tdi;
  logic        tdo;
  logic [1:0]  ir_in;
  logic [1:0]  ir_out;
  logic        cdr, sdr, udr, uir;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem [0:65535];
  logic [15:0] log_a[$];
  logic [7:0]  log_d[$];
  int          re_cnt = 0;
  int          both_cnt = 0;
  int          n_chk = 0;
  int          n_bad = 0;
  int          wr_idx = 0;
  logic        we_at_udr;
  logic [31:0] dout;

  always #5 tck = ~tck;

  vjtag_dsa_ctrl #(.DATA_W(8), .ADDR_W(16)) dut (
    .tck               (tck),
    .rst_n             (rst_n),
    .tdi               (tdi),
    .tdo               (tdo),
    .ir_in             (ir_in),
    .ir_out            (ir_out),
    .virtual_state_cdr (cdr),
    .virtual_state_sdr (sdr),
    .virtual_state_udr (udr),
    .virtual_state_uir (uir),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_we            (mem_we),
    .mem_re            (mem_re),
    .mem_rdata         (mem_rdata)
  );

  always @(posedge tck) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      log_a.push_back(mem_addr);
      log_d.push_back(mem_wdata);
    end
    if (mem_re) begin
      mem_rdata <= mem[mem_addr];
      re_cnt++;
    end
    if (mem_we && mem_re) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge tck);
      #1;
    end
  endtask

  task automatic ir_scan(input logic [1:0] code);
    ir_in = code;
    uir   = 1'b1;
    cyc(1);
    uir   = 1'b0;
    cyc(2);
  endtask

  task automatic dr_scan(input int n, input logic [31:0] din, output logic [31:0] dout_o);
    dout_o = '0;
    cdr = 1'b1;
    cyc(1);
    cdr = 1'b0;
    sdr = 1'b1;
    for (int i = 0; i < n; i++) begin
      tdi = din[i];
      #1 dout_o[i] = tdo;
      cyc(1);
    end
    sdr = 1'b0;
    udr = 1'b1;
    cyc(1);
    we_at_udr = mem_we;
    udr = 1'b0;
    cyc(2);
  endtask

  task automatic exp_wr(input string tag, input logic [15:0] a, input logic [7:0] d);
    if (wr_idx < log_a.size())
      check(tag, {8'h00, log_a[wr_idx], log_d[wr_idx]}, {8'h00, a, d});
    else
      check({tag, "_missing"}, log_a.size(), wr_idx + 1);
    wr_idx++;
  endtask

  initial begin
    int w0, r0;
    logic [3:0] pat;
    logic [7:0] rexp [3];
    rexp[0] = 8'hA1; rexp[1] = 8'hB2; rexp[2] = 8'hC3;

    rst_n = 1'b0; tdi = 1'b0; ir_in = 2'b00;
    cdr = 1'b0; sdr = 1'b0; udr = 1'b0; uir = 1'b0;
    cyc(2);
    check("reset_outs", {3'b0, tdo, ir_out, mem_addr, mem_wdata, mem_we, mem_re}, 32'h0);
    rst_n = 1'b1;
    cyc(1);

    // 1: sequential writes with auto-increment
    ir_scan(2'b01); dr_scan(16, 32'h0010, dout);
    ir_scan(2'b10);
    dr_scan(8, 32'hA1, dout);
    check("t1_we_lat", {31'b0, we_at_udr}, 32'h1);
    dr_scan(8, 32'hB2, dout);
    dr_scan(8, 32'hC3, dout);
    dr_scan(8, 32'hD4, dout);
    exp_wr("t1_w0", 16'h0010, 8'hA1);
    exp_wr("t1_w1", 16'h0011, 8'hB2);
    exp_wr("t1_w2", 16'h0012, 8'hC3);
    exp_wr("t1_addr13", 16'h0013, 8'hD4);

    // 2: read back with prefetch
    ir_scan(2'b01); dr_scan(16, 32'h0010, dout);
    r0 = re_cnt;
    ir_scan(2'b11);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t2_valid%0d", i), {31'b0, ir_out[0]}, 32'h1);
      dr_scan(8, 32'h0, dout);
      check($sformatf("t2_rd%0d", i), {24'b0, dout[7:0]}, {24'b0, rexp[i]});
    end
    check("t2_re_cnt", re_cnt - r0, 32'd4);
    check("t2_no_wr", log_a.size(), 32'd4);

    // 3: address wrap and sticky flag
    ir_scan(2'b01); dr_scan(16, 32'hFFFF, dout);
    ir_scan(2'b10); dr_scan(8, 32'h55, dout);
    exp_wr("t3_wFFFF", 16'hFFFF, 8'h55);
    check("t3_wrap_set", {31'b0, ir_out[1]}, 32'h1);
    dr_scan(8, 32'h66, dout);
    exp_wr("t3_w0000", 16'h0000, 8'h66);
    ir_scan(2'b01); dr_scan(16, 32'h0020, dout);
    check("t3_wrap_clr", {31'b0, ir_out[1]}, 32'h0);

    // 4: bypass delays tdi by one tck
    ir_scan(2'b00);
    w0 = log_a.size(); r0 = re_cnt;
    pat = 4'b1101;  // shifted in order 1,0,1,1
    cdr = 1'b1; cyc(1); cdr = 1'b0;
    sdr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tdi = pat[i];
      #1 check($sformatf("t4_byp%0d", i), {31'b0, tdo}, (i == 0) ? 32'h0 : {31'b0, pat[i-1]});
      cyc(1);
    end
    sdr = 1'b0;
    check("t4_byp_hold", {31'b0, tdo}, 32'h1);
    udr = 1'b1; cyc(1); udr = 1'b0; cyc(2);
    check("t4_no_strobe", (log_a.size() - w0) + (re_cnt - r0), 32'h0);

    // 5: pause mid-shift keeps partial data
    ir_scan(2'b01); dr_scan(16, 32'h0030, dout);
    ir_scan(2'b10);
    cdr = 1'b1; cyc(1); cdr = 1'b0;
    sdr = 1'b1;
    for (int i = 0; i < 4; i++) begin tdi = pat[i] ^ (i[0] ? 1'b0 : 1'b1) ^ 1'b1; tdi = (8'h5A >> i) & 8'h1; cyc(1); end
    sdr = 1'b0;
    cyc(10);
    sdr = 1'b1;
    for (int i = 4; i < 8; i++) begin tdi = (8'h5A >> i) & 8'h1; cyc(1); end
    sdr = 1'b0;
    udr = 1'b1; cyc(1);
    check("t5_we_lat", {31'b0, mem_we}, 32'h1);
    udr = 1'b0; cyc(2);
    exp_wr("t5_w30", 16'h0030, 8'h5A);

    // 6: async reset mid-shift
    w0 = log_a.size();
    cdr = 1'b1; cyc(1); cdr = 1'b0;
    sdr = 1'b1; tdi = 1'b1;
    cyc(3);
    check("t6_pre_tdo", {31'b0, tdo}, 32'h1);
    #2 rst_n = 1'b0;
    #1 check("t6_async", {3'b0, tdo, ir_out, mem_addr, mem_wdata, mem_we, mem_re}, 32'h0);
    sdr = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    cdr = 1'b1; cyc(1); cdr = 1'b0;
    check("t6_discard", {31'b0, tdo}, 32'h0);
    sdr = 1'b1;
    cyc(8);
    sdr = 1'b0;
    cyc(3);
    check("t6_no_we", log_a.size() - w0, 32'h0);
    check("we_re_overlap", both_cnt, 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
